// File: rtl/present_pkg.sv
// present_pkg: widths, FSM state type and operand payload shared by the
// PRESENT loader, the cipher core and any downstream checker.
package present_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STATE_BYTES = 8;
  localparam int unsigned STATE_W     = STATE_BYTES * BYTE_W;  // 64
  localparam int unsigned KEY_W       = 80;
  localparam int unsigned FRAME_BYTES = 18;
  localparam int unsigned FRAME_W     = STATE_W + KEY_W;       // 144
  localparam int unsigned SHADOW_W    = FRAME_W - BYTE_W;      // all bytes but the last
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned HOLD_W      = 16;
  localparam int unsigned COUNT_W     = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    LOAD    = 2'd2,
    HOLD    = 2'd3
  } fsm_state_t;

  // Operands as presented to the cipher core, MSB first.
  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [KEY_W-1:0]   keys;
  } frame_t;

endpackage

// File: rtl/present_load.sv
// present_load: collects an 18-byte frame (8 plaintext bytes then 10 key
// bytes, MSB first) from a valid/ready byte stream, publishes it as the
// cipher core's state/keys operands with a one-cycle load strobe, then
// stalls input for HOLD_CYCLES cycles while the core runs.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   in_data/in_valid/in_last byte stream input, in_ready back-pressure
//   state, keys             operands to the core (bit 0 is MSB)
//   load                    one-cycle strobe: operands newly valid
//   frame_err               one-cycle strobe: malformed frame discarded
//   frame_count             successful loads, wrapping
module present_load
  import present_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [0:STATE_W-1]   state,
  output logic [0:KEY_W-1]     keys,
  output logic                 load,
  output logic                 frame_err,
  output logic [COUNT_W-1:0]   frame_count
);

  fsm_state_t          r_fsm;
  fsm_state_t          w_fsm_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [SHADOW_W-1:0] r_shadow;
  logic [STATE_W-1:0]  r_state;
  logic [KEY_W-1:0]    r_keys;
  logic [COUNT_W-1:0]  r_count;
  logic                r_in_ready;
  logic                r_load;
  logic                r_err;

  logic                w_beat;
  logic                w_last_idx;
  logic                w_store;
  logic                w_commit;
  logic                w_err;
  logic                w_ready_nxt;
  frame_t              w_frame;

  assign w_beat     = in_valid && r_in_ready;
  assign w_last_idx = (r_idx == IDX_W'(FRAME_BYTES - 1));
  // The final byte bypasses the shadow so operands update on its own edge.
  assign w_frame    = frame_t'({r_shadow, in_data});

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fsm <= COLLECT;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_idx_nxt  = r_idx;
    w_hold_nxt = r_hold;
    w_store    = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    case (r_fsm)
      COLLECT: begin
        if (w_beat) begin
          if (!w_last_idx) begin
            if (in_last) begin
              w_err     = 1'b1;
              w_idx_nxt = '0;
            end else begin
              w_store   = 1'b1;
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_idx_nxt = '0;
            if (in_last) begin
              w_commit  = 1'b1;
              w_fsm_nxt = LOAD;
            end else begin
              w_err     = 1'b1;
              w_fsm_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (w_beat && in_last) begin
          w_idx_nxt = '0;
          w_fsm_nxt = COLLECT;
        end
      end
      LOAD: begin
        w_hold_nxt = HOLD_W'(HOLD_CYCLES);
        w_fsm_nxt  = HOLD;
      end
      HOLD: begin
        if (r_hold <= HOLD_W'(1)) begin
          w_fsm_nxt = COLLECT;
        end else begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end
      end
      default: begin
        w_fsm_nxt = COLLECT;
      end
    endcase
    // Registered ready follows the state being entered, never in_valid.
    w_ready_nxt = (w_fsm_nxt == COLLECT) || (w_fsm_nxt == DRAIN);
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_idx      <= '0;
      r_hold     <= '0;
      r_shadow   <= '0;
      r_state    <= '0;
      r_keys     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_load     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_hold     <= w_hold_nxt;
      r_in_ready <= w_ready_nxt;
      r_load     <= w_commit;
      r_err      <= w_err;
      if (w_store) begin
        r_shadow <= {r_shadow[SHADOW_W-BYTE_W-1:0], in_data};
      end
      if (w_commit) begin
        r_state <= w_frame.state;
        r_keys  <= w_frame.keys;
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign state       = r_state;
  assign keys        = r_keys;
  assign load        = r_load;
  assign frame_err   = r_err;
  assign frame_count = r_count;

endmodule

// File: tb/tb_present_load.sv
// tb_present_load: random-gap byte stream driver with a frame-level
// reference model (frame length decides error/load, operands built from
// byte positions) for present_load.
module tb_present_load;
  import present_pkg::*;

  localparam int unsigned TB_HOLD = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic [7:0]         in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic [0:63]        state;
  logic [0:79]        keys;
  logic               load;
  logic               frame_err;
  logic [15:0]        frame_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_state = '0;
  logic [79:0] m_keys  = '0;
  logic [15:0] m_count = '0;
  byte unsigned fq[$];

  present_load #(.HOLD_CYCLES(TB_HOLD)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .state       (state),
    .keys        (keys),
    .load        (load),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 144'(in_ready), 144'(0));
    chk({tag, "_state"}, 144'(state), 144'(0));
    chk({tag, "_keys"}, 144'(keys), 144'(0));
    chk({tag, "_load"}, 144'(load), 144'(0));
    chk({tag, "_err"}, 144'(frame_err), 144'(0));
    chk({tag, "_count"}, 144'(frame_count), 144'(0));
  endtask

  // One beat; returns how many cycles in_valid waited on in_ready.
  task automatic send_byte(input byte unsigned d, input bit last, input bit allow_idle,
                           output int stalls);
    int idle;
    idle = allow_idle ? int'($urandom_range(2, 0)) : 0;
    repeat (idle) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge sys_clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    stalls   = 0;
    while (in_ready !== 1'b1 && stalls < 200) begin
      @(negedge sys_clk);
      stalls++;
    end
    if (stalls >= 200) begin
      n_checks++;
      n_errors++;
      $error("FAIL handshake_timeout: observed %0d stall cycles expected fewer than 200", stalls);
    end else begin
      @(negedge sys_clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Sends fq as one frame (in_last on its final byte) and checks every beat.
  task automatic send_frame(input bit allow_idle, input bit first_no_idle, input string tag,
                            output int first_stalls);
    int len;
    int err_pos;
    int st;
    len = fq.size();
    first_stalls = 0;
    if (len < 18)      err_pos = len - 1;
    else if (len > 18) err_pos = 17;
    else               err_pos = -1;
    for (int i = 0; i < len; i++) begin
      send_byte(fq[i], (i == len - 1), allow_idle && !(i == 0 && first_no_idle), st);
      if (i == 0) first_stalls = st;
      chk({tag, "_err"}, 144'(frame_err), 144'(i == err_pos));
      chk({tag, "_load"}, 144'(load), 144'(len == 18 && i == 17));
    end
    if (len == 18) begin
      for (int i = 0; i < 8; i++)  m_state[63 - 8 * i -: 8] = fq[i];
      for (int i = 8; i < 18; i++) m_keys[79 - 8 * (i - 8) -: 8] = fq[i];
      m_count = m_count + 16'd1;
    end
    chk({tag, "_state"}, 144'(state), 144'(m_state));
    chk({tag, "_keys"}, 144'(keys), 144'(m_keys));
    chk({tag, "_count"}, 144'(frame_count), 144'(m_count));
  endtask

  task automatic fill_random(input int len);
    fq.delete();
    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
  endtask

  task automatic model_reset();
    m_state = '0;
    m_keys  = '0;
    m_count = '0;
  endtask

  initial begin
    int st;
    int sel;
    int len;

    // Reset values
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("ready_after_reset", 144'(in_ready), 144'(1));

    // Nominal all-ones frame
    fq.delete();
    for (int i = 0; i < 18; i++) fq.push_back(8'hFF);
    send_frame(1'b0, 1'b0, "nominal", st);
    chk("nominal_state_const", 144'(state), 144'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("nominal_keys_const", 144'(keys), 144'(80'hFFFF_FFFF_FFFF_FFFF_FFFF));
    chk("nominal_count_const", 144'(frame_count), 144'(1));
    @(negedge sys_clk);
    chk("load_one_cycle", 144'(load), 144'(0));

    // Byte ordering
    fq.delete();
    for (int i = 0; i < 18; i++) fq.push_back(8'(i));
    send_frame(1'b1, 1'b0, "order", st);
    chk("order_state_const", 144'(state), 144'(64'h0001_0203_0405_0607));
    chk("order_keys_const", 144'(keys), 144'(80'h0809_0A0B_0C0D_0E0F_1011));

    // Back-to-back frames: first byte of the second frame waits HOLD+1 cycles
    fill_random(18);
    send_frame(1'b0, 1'b1, "bp1", st);
    fill_random(18);
    send_frame(1'b0, 1'b1, "bp2", st);
    chk("bp_stall_cycles", 144'(st), 144'(TB_HOLD + 1));

    // Short frame, then clean frame
    fill_random(10);
    send_frame(1'b1, 1'b0, "short", st);
    @(negedge sys_clk);
    chk("short_err_one_cycle", 144'(frame_err), 144'(0));
    fill_random(18);
    send_frame(1'b1, 1'b0, "after_short", st);

    // Long frame, then clean frame
    fill_random(22);
    send_frame(1'b1, 1'b0, "long", st);
    fill_random(18);
    send_frame(1'b1, 1'b0, "after_long", st);

    // Random frame lengths with random gaps
    for (int n = 0; n < 20; n++) begin
      sel = int'($urandom_range(3, 0));
      if (sel == 1)      len = int'($urandom_range(17, 1));
      else if (sel == 2) len = int'($urandom_range(24, 19));
      else               len = 18;
      fill_random(len);
      send_frame(1'b1, 1'b0, "rand", st);
    end

    // Reset mid-frame after 10 bytes
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, 1'b1, st);
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("rst_midframe");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    @(negedge sys_clk);
    chk("rst_midframe_ready", 144'(in_ready), 144'(1));
    fill_random(18);
    send_frame(1'b1, 1'b0, "fresh1", st);
    chk("fresh1_count_const", 144'(frame_count), 144'(1));

    // Reset during HOLD
    repeat (2) @(negedge sys_clk);
    chk("in_hold_ready", 144'(in_ready), 144'(0));
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("rst_hold");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    @(negedge sys_clk);
    fill_random(18);
    send_frame(1'b1, 1'b0, "fresh2", st);
    chk("fresh2_count_const", 144'(frame_count), 144'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
